// File: rtl/ram_2p_pipe.sv
// ram_2p_pipe: true dual-port synchronous RAM with per-byte write enables.
// Each accepted request returns one response after ReadLatency (1 or 2) cycles.
// Out-of-range accesses do not touch memory and respond with err=1, rdata=0.
// Reads return the word as it was before the same edge's writes.
// When both ports write the same byte, port A wins.
module ram_2p_pipe #(
    parameter int unsigned Depth       = 128,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned ReadLatency = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   a_req_i,
    input  logic                   a_we_i,
    input  logic [DataWidth/8-1:0] a_be_i,
    input  logic [AddrWidth-1:0]   a_addr_i,
    input  logic [DataWidth-1:0]   a_wdata_i,
    output logic                   a_rvalid_o,
    output logic [DataWidth-1:0]   a_rdata_o,
    output logic                   a_err_o,
    input  logic                   b_req_i,
    input  logic                   b_we_i,
    input  logic [DataWidth/8-1:0] b_be_i,
    input  logic [AddrWidth-1:0]   b_addr_i,
    input  logic [DataWidth-1:0]   b_wdata_i,
    output logic                   b_rvalid_o,
    output logic [DataWidth-1:0]   b_rdata_o,
    output logic                   b_err_o
);

    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned ByteOff  = $clog2(NumBytes);
    localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;
    // Wide enough to hold both the full word index and Depth, so nothing aliases.
    localparam int unsigned CmpWidth = AddrWidth + 32;

    if (ReadLatency != 1 && ReadLatency != 2) begin : g_bad_latency
        $error("ram_2p_pipe: ReadLatency must be 1 or 2");
    end

    // Port 0 is A and port 1 is B, so both ports share one datapath description.
    logic [1:0]           req;
    logic [1:0]           we;
    logic [NumBytes-1:0]  be       [2];
    logic [AddrWidth-1:0] addr     [2];
    logic [DataWidth-1:0] wdata    [2];
    logic [AddrWidth-1:0] idx      [2];
    logic [IdxWidth-1:0]  widx     [2];
    logic [1:0]           in_range;
    logic [1:0]           wr;

    logic [DataWidth-1:0] mem [Depth];

    assign req      = {b_req_i, a_req_i};
    assign we       = {b_we_i, a_we_i};
    assign be[0]    = a_be_i;
    assign be[1]    = b_be_i;
    assign addr[0]  = a_addr_i;
    assign addr[1]  = b_addr_i;
    assign wdata[0] = a_wdata_i;
    assign wdata[1] = b_wdata_i;

    // Decode each port's word index, range check and write qualification.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            idx[p]      = addr[p] >> ByteOff;
            in_range[p] = CmpWidth'(idx[p]) < CmpWidth'(Depth);
            widx[p]     = idx[p][IdxWidth-1:0];
            wr[p]       = rst_ni & req[p] & we[p] & in_range[p];
        end
    end

    // Byte-masked writes; port A's assignment comes last, so it wins on collisions.
    // NOTE: memory has no reset; its contents are undefined until written.
    // NOTE: non-blocking assignments make the later port-A write override port B.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumBytes; i++) begin
            if (wr[1] && be[1][i]) mem[widx[1]][i*8 +: 8] <= wdata[1][i*8 +: 8];
            if (wr[0] && be[0][i]) mem[widx[0]][i*8 +: 8] <= wdata[0][i*8 +: 8];
        end
    end

    logic [1:0]           v1;
    logic [1:0]           e1;
    logic [DataWidth-1:0] d1 [2];

    // First response stage: captures the pre-write word; data and err hold between requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1    <= '0;
            e1    <= '0;
            d1[0] <= '0;
            d1[1] <= '0;
        end else begin
            v1 <= req;
            for (int p = 0; p < 2; p++) begin
                if (req[p]) begin
                    e1[p] <= ~in_range[p];
                    d1[p] <= in_range[p] ? mem[widx[p]] : '0;
                end
            end
        end
    end

    if (ReadLatency == 2) begin : g_lat2
        logic [1:0]           v2;
        logic [1:0]           e2;
        logic [DataWidth-1:0] d2 [2];

        // Extra output stage; only loads on a valid response so outputs hold otherwise.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v2    <= '0;
                e2    <= '0;
                d2[0] <= '0;
                d2[1] <= '0;
            end else begin
                v2 <= v1;
                for (int p = 0; p < 2; p++) begin
                    if (v1[p]) begin
                        e2[p] <= e1[p];
                        d2[p] <= d1[p];
                    end
                end
            end
        end

        assign a_rvalid_o = v2[0];
        assign a_rdata_o  = d2[0];
        assign a_err_o    = e2[0];
        assign b_rvalid_o = v2[1];
        assign b_rdata_o  = d2[1];
        assign b_err_o    = e2[1];
    end else begin : g_lat1
        assign a_rvalid_o = v1[0];
        assign a_rdata_o  = d1[0];
        assign a_err_o    = e1[0];
        assign b_rvalid_o = v1[1];
        assign b_rdata_o  = d1[1];
        assign b_err_o    = e1[1];
    end

endmodule

// File: tb/tb_ram_2p_pipe.sv
// Bench for ram_2p_pipe. Three instances receive identical stimulus:
// d0 = Depth 128 / latency 1, d1 = Depth 100 / latency 1, d2 = Depth 128 / latency 2.
// A word-level memory model plus per-port queues of time-stamped expected
// responses predict every output on every cycle.
module tb_ram_2p_pipe;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_be, b_be;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;

    // Output slots: 2*d is port A of instance d, 2*d+1 is port B.
    logic [5:0]  rv, er;
    logic [31:0] rd [6];

    always #5 clk_i = ~clk_i;

    ram_2p_pipe #(.Depth(128), .DataWidth(32), .AddrWidth(32), .ReadLatency(1)) u_d0 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .a_req_i(a_req), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_rvalid_o(rv[0]), .a_rdata_o(rd[0]), .a_err_o(er[0]),
        .b_req_i(b_req), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_rvalid_o(rv[1]), .b_rdata_o(rd[1]), .b_err_o(er[1])
    );

    ram_2p_pipe #(.Depth(100), .DataWidth(32), .AddrWidth(32), .ReadLatency(1)) u_d1 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .a_req_i(a_req), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_rvalid_o(rv[2]), .a_rdata_o(rd[2]), .a_err_o(er[2]),
        .b_req_i(b_req), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_rvalid_o(rv[3]), .b_rdata_o(rd[3]), .b_err_o(er[3])
    );

    ram_2p_pipe #(.Depth(128), .DataWidth(32), .AddrWidth(32), .ReadLatency(2)) u_d2 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .a_req_i(a_req), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_rvalid_o(rv[4]), .a_rdata_o(rd[4]), .a_err_o(er[4]),
        .b_req_i(b_req), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_rvalid_o(rv[5]), .b_rdata_o(rd[5]), .b_err_o(er[5])
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t       q [6][$];
    logic [31:0] mb [128];
    logic [31:0] ms [100];
    logic [31:0] last_d [6];
    logic        last_e [6];
    int          n;
    int          tests;
    int          fails;

    function automatic int lat_of(int d);
        return (d == 2) ? 2 : 1;
    endfunction

    function automatic int depth_of(int d);
        return (d == 1) ? 100 : 128;
    endfunction

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s slot=%0d cycle=%0d observed=%h expected=%h", tag, k, n, obs, exp);
        end
    endtask

    task automatic write_byte(logic [31:0] idx, int i, logic [31:0] data);
        if (idx < 128) mb[idx][8*i +: 8] = data[8*i +: 8];
        if (idx < 100) ms[idx][8*i +: 8] = data[8*i +: 8];
    endtask

    // Predict responses from pre-edge contents, then apply this edge's writes.
    task automatic model_edge();
        logic        req [2];
        logic        we  [2];
        logic [3:0]  be  [2];
        logic [31:0] wd  [2];
        logic [31:0] idx [2];
        resp_t       r;
        req[0] = a_req;  we[0] = a_we;  be[0] = a_be;  wd[0] = a_wdata;  idx[0] = a_addr >> 2;
        req[1] = b_req;  we[1] = b_we;  be[1] = b_be;  wd[1] = b_wdata;  idx[1] = b_addr >> 2;
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (req[p]) begin
                    r.due = n + lat_of(d) - 1;
                    if (idx[p] >= 32'(depth_of(d))) begin
                        r.err  = 1'b1;
                        r.data = '0;
                    end else begin
                        r.err  = 1'b0;
                        r.data = (d == 1) ? ms[idx[p]] : mb[idx[p]];
                    end
                    q[d*2+p].push_back(r);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (req[1] && we[1] && be[1][i] &&
                !(req[0] && we[0] && be[0][i] && idx[0] == idx[1]))
                write_byte(idx[1], i, wd[1]);
            if (req[0] && we[0] && be[0][i])
                write_byte(idx[0], i, wd[0]);
        end
    endtask

    // Every output slot either shows its due response or idles with held data/err.
    task automatic check_all();
        resp_t r;
        for (int k = 0; k < 6; k++) begin
            if (q[k].size() > 0 && q[k][0].due == n) begin
                r = q[k].pop_front();
                chk("rvalid", k, 32'(rv[k]), 32'd1);
                chk("rdata", k, rd[k], r.data);
                chk("err", k, 32'(er[k]), 32'(r.err));
                last_d[k] = r.data;
                last_e[k] = r.err;
            end else begin
                chk("rvalid_idle", k, 32'(rv[k]), 32'd0);
                chk("rdata_hold", k, rd[k], last_d[k]);
                chk("err_hold", k, 32'(er[k]), 32'(last_e[k]));
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        n++;
        if (rst_ni) model_edge();
        @(negedge clk_i);
        check_all();
    endtask

    task automatic set_a(logic r, logic w, logic [3:0] b, logic [31:0] ad, logic [31:0] d);
        a_req = r;  a_we = w;  a_be = b;  a_addr = ad;  a_wdata = d;
    endtask

    task automatic set_b(logic r, logic w, logic [3:0] b, logic [31:0] ad, logic [31:0] d);
        b_req = r;  b_we = w;  b_be = b;  b_addr = ad;  b_wdata = d;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return $urandom;
        return 32'($urandom_range(0, 150 * 4 - 1));
    endfunction

    initial begin
        logic [31:0] saved;
        tests = 0;
        fails = 0;
        n     = 0;
        for (int k = 0; k < 6; k++) begin
            last_d[k] = '0;
            last_e[k] = 1'b0;
        end
        rst_ni = 1'b0;
        set_a(0, 0, 4'h0, 0, 0);
        set_b(0, 0, 4'h0, 0, 0);

        // Reset state: everything zero.
        #12;
        check_all();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fill every word of the larger memory with random data (d1 errors above 99).
        for (int i = 0; i < 128; i++) begin
            set_a(1, 1, 4'hF, 32'(i * 4), $urandom);
            cycle();
        end

        // Single-port write then readback; the write also returns a response.
        set_a(1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
        cycle();
        set_a(1, 0, 4'hF, 32'h10, 32'h0);
        cycle();
        chk("dir_readback", 0, rd[0], 32'hDEADBEEF);
        chk("dir_readback_err", 0, 32'(er[0]), 32'd0);

        // Byte enables.
        set_a(1, 1, 4'hF, 32'h20, 32'h11223344);
        cycle();
        set_a(1, 1, 4'h5, 32'h20, 32'hAABBCCDD);
        cycle();
        set_a(1, 0, 4'h0, 32'h22, 32'h0);
        cycle();
        chk("dir_byte_en", 0, rd[0], 32'h11BB33DD);

        // Collision at index 5, then cross-port read-old-data.
        set_a(1, 1, 4'hF, 32'h14, 32'h12345678);
        cycle();
        set_a(1, 1, 4'h1, 32'h14, 32'h000000AA);
        set_b(1, 1, 4'h3, 32'h15, 32'h0000BBCC);
        cycle();
        set_a(1, 0, 4'h0, 32'h14, 32'h0);
        set_b(0, 0, 4'h0, 32'h0, 32'h0);
        cycle();
        chk("dir_collision", 0, rd[0], 32'h1234BBAA);
        set_a(1, 1, 4'hF, 32'h14, 32'hFFFFFFFF);
        set_b(1, 0, 4'h0, 32'h14, 32'h0);
        cycle();
        chk("dir_read_old", 1, rd[1], 32'h1234BBAA);
        set_b(0, 0, 4'h0, 32'h0, 32'h0);
        set_a(1, 0, 4'h0, 32'h14, 32'h0);
        cycle();

        // Out of range on the Depth=100 instance.
        set_a(1, 1, 4'hF, 32'd400, 32'h55555555);
        cycle();
        chk("dir_oor_err", 2, 32'(er[2]), 32'd1);
        chk("dir_oor_rdata", 2, rd[2], 32'h0);
        chk("dir_inrange128_err", 0, 32'(er[0]), 32'd0);
        set_a(1, 1, 4'hF, 32'h8000_0000, 32'h66666666);
        cycle();
        chk("dir_oor_high", 0, 32'(er[0]), 32'd1);
        set_a(1, 0, 4'h0, 32'd396, 32'h0);
        cycle();
        chk("dir_last_word", 2, 32'(er[2]), 32'd0);
        set_a(1, 0, 4'h0, 32'd0, 32'h0);
        cycle();

        // Streaming reads on 8 consecutive cycles.
        for (int i = 0; i < 8; i++) begin
            set_a(1, 0, 4'h0, 32'(i * 4), 32'h0);
            cycle();
        end
        set_a(0, 0, 4'h0, 0, 0);
        for (int i = 0; i < 3; i++) cycle();

        // Random traffic on both ports.
        for (int i = 0; i < 400; i++) begin
            set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  rand_addr(), $urandom);
            set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  rand_addr(), $urandom);
            if ($urandom_range(0, 7) == 0) b_addr = a_addr;
            cycle();
        end
        set_a(0, 0, 4'h0, 0, 0);
        set_b(0, 0, 4'h0, 0, 0);
        for (int i = 0; i < 3; i++) cycle();

        // Reset mid-flight: in-flight responses are dropped, memory kept.
        saved = mb[4];
        set_a(1, 0, 4'h0, 32'h10, 32'h0);
        @(posedge clk_i);
        n++;
        model_edge();
        #2;
        rst_ni = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) begin
            q[k].delete();
            last_d[k] = '0;
            last_e[k] = 1'b0;
        end
        check_all();
        set_a(1, 1, 4'hF, 32'h10, 32'hCAFEF00D);
        cycle();
        cycle();
        rst_ni = 1'b1;
        set_a(0, 0, 4'h0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        set_a(1, 0, 4'h0, 32'h10, 32'h0);
        cycle();
        chk("dir_mem_kept", 0, rd[0], saved);
        set_a(0, 0, 4'h0, 0, 0);
        for (int i = 0; i < 3; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_2p_pipe.md
Name: ram_2p_pipe

Overview:
- True dual-port synchronous RAM with ports A and B.
- Generalised data width, depth and read latency (1 or 2 cycles), with per-byte write enables.
- Flags out-of-range accesses and resolves same-address write collisions deterministically.
- Used as shared instruction/data memory in simulation and FPGA tops, one port per core interface or one per core plus a debug/loader port.

Parameters:
- Depth, 128, number of DataWidth-bit words; any value >= 2, not required to be a power of two.
- DataWidth, 32, word width in bits; must be a multiple of 8 and a power of two >= 8.
- AddrWidth, 32, width of byte address inputs.
- ReadLatency, 1, cycles from accepted request to rvalid; legal values 1 or 2; other values are rejected by an elaboration-time assertion.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- a_req_i  in  1  port A request; accepted every cycle it is high, no backpressure
- a_we_i  in  1  port A write enable (qualified by a_req_i)
- a_be_i  in  DataWidth/8  port A byte enables
- a_addr_i  in  AddrWidth  port A byte address
- a_wdata_i  in  DataWidth  port A write data
- a_rvalid_o  out  1  port A response valid
- a_rdata_o  out  DataWidth  port A read data
- a_err_o  out  1  port A response error, valid with a_rvalid_o
- b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i, b_rvalid_o, b_rdata_o, b_err_o: identical to port A, for port B.

Behaviour:
- Address decode:
  - ByteOff = log2(DataWidth/8); word index = addr >> ByteOff, computed over the full width.
  - Low ByteOff address bits are ignored.
  - Access is out of range if the word index >= Depth.
- Accepted request (req high at a clock edge):
  - Write: for each i with be[i]=1, byte i of mem[index] takes wdata byte i. Bytes with be[i]=0 are unchanged.
  - Every accepted request, read or write, yields exactly one response. rdata = mem[index] as it was before this edge's writes (read-old-data, both same-port and cross-port).
- Out-of-range request:
  - No memory update.
  - Response has err=1 and rdata=0.
  - In-range responses have err=0.
- Write collision (both ports write the same in-range index in the same cycle):
  - Port A wins per byte where both be bits are set.
  - Bytes enabled on only one port take that port's data.
- Latency:
  - ReadLatency=1: rvalid/rdata/err appear the cycle after the request edge.
  - ReadLatency=2: one extra output register stage; responses one cycle later.
  - Back-to-back requests on every cycle produce back-to-back responses, in order, one per cycle per port. Ports are fully independent.
- Between responses:
  - rdata and err hold their last value while rvalid=0.
  - rvalid is a single-cycle pulse per request.
- Reset:
  - Asynchronous, active-low, on rst_ni.
  - All pipeline valid bits, rvalid_o, err_o and rdata_o go to 0 for both ports.
  - Memory contents are not reset; they are undefined until written.
  - Reset asserted mid-operation discards all in-flight responses: no rvalid after deassertion for requests issued before or during reset.
  - Requests are ignored (no write, no response) while rst_ni=0.
- Widths: be width is DataWidth/8. No arithmetic beyond the index compare; the compare is done at full address width, so no truncation aliasing.

Test Plan:
- Single-port write/readback, DataWidth=32, Depth=128, ReadLatency=1:
  - A writes 0xDEADBEEF to byte addr 0x10 (be=0xF), then reads 0x10.
  - Read response the next cycle: rdata=0xDEADBEEF, err=0; the write request also returns an rvalid pulse.
- Byte enables:
  - Write 0x11223344 to 0x20 with be=0xF, then write 0xAABBCCDD with be=0x5.
  - A read returns 0x11BB33DD.
- Collision and read-old-data:
  - Same cycle: A writes 0x000000AA be=0x1 and B writes 0x0000BBCC be=0x3 to index 5; 0x12345678 was previously stored there.
  - Subsequent read returns 0x1234BBAA.
  - A simultaneous B read of index 5 in a later write cycle returns pre-write data.
- Out-of-range, Depth=100:
  - Write to byte addr 400 (index 100): response err=1, rdata=0, memory unchanged.
  - Address 0x8000_0000: err=1.
  - Address 396 (index 99): err=0.
- ReadLatency=2 streaming:
  - Reads on 8 consecutive cycles to indices 0..7 on port A.
  - rvalid high for exactly 8 consecutive cycles, starting 2 cycles after the first request, data in order.
- Reset mid-flight, ReadLatency=2:
  - Issue a read, then pull rst_ni low asynchronously between clock edges on the next cycle.
  - Outputs go to 0 immediately; no rvalid after release; memory retains prior writes.
